// File: rtl/polyphase_split.sv
// Input commutator for the halfband polyphase decimator: pairs x[2n]/x[2n+1], buffers
// whole pairs in a small FIFO and fires both branch enables together. Optional macro: SPLIT_DROP_CNT_EN.
module polyphase_split #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 16
) (
  input  logic                          clk_var,
  input  logic                          reset,
  input  logic                          enable,
  input  logic [DATA_W-1:0]             in_data,
  input  logic                          in_valid,
  input  logic                          out_ready,
  output logic [DATA_W-1:0]             even_data,
  output logic [DATA_W-1:0]             odd_data,
  output logic                          branch_en,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow,
  output logic [CNT_W-1:0]              drop_count,
  output logic                          phase_dbg
);

  localparam int AW = $clog2(FIFO_DEPTH);

  // Handshake: the source has no backpressure, so every in_valid sample taken while
  // enable=1 is consumed; a pair leaves the FIFO on any enabled cycle where the FIFO
  // is non-empty and out_ready=1, and appears one edge later with branch_en high.

  typedef enum logic {
    S_EVEN = 1'b0,
    S_ODD  = 1'b1
  } phase_t;

  phase_t                 phase;
  logic [DATA_W-1:0]      hold;
  logic [2*DATA_W-1:0]    mem [FIFO_DEPTH];
  logic [AW:0]            wr_ptr;
  logic [AW:0]            rd_ptr;
  logic                   branch_q;

  logic empty;
  logic full;
  logic push_req;
  logic pop;
  logic do_push;
  logic drop;

  // The extra pointer MSB distinguishes full from empty when the indices match.
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign push_req = enable && in_valid && (phase == S_ODD);
  assign pop      = enable && !empty && out_ready;
  assign do_push  = push_req && (!full || pop);
  assign drop     = push_req && full && !pop;

  assign fifo_level = wr_ptr - rd_ptr;
  assign branch_en  = branch_q && enable;
  assign phase_dbg  = (phase == S_ODD);

  always_ff @(posedge clk_var) begin
    if (do_push) begin
      mem[wr_ptr[AW-1:0]] <= {hold, in_data};
    end
  end

  always_ff @(posedge clk_var) begin
    if (reset) begin
      phase     <= S_EVEN;
      hold      <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      even_data <= '0;
      odd_data  <= '0;
      branch_q  <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      // pop already includes enable, so a disabled cycle clears the pulse.
      branch_q <= pop;
      if (enable && in_valid) begin
        case (phase)
          S_EVEN: begin
            hold  <= in_data;
            phase <= S_ODD;
          end
          S_ODD: begin
            phase <= S_EVEN;
          end
          default: phase <= S_EVEN;
        endcase
      end
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr    <= rd_ptr + 1'b1;
        even_data <= mem[rd_ptr[AW-1:0]][2*DATA_W-1:DATA_W];
        odd_data  <= mem[rd_ptr[AW-1:0]][DATA_W-1:0];
      end
      if (drop) begin
        overflow <= 1'b1;
      end
    end
  end

`ifdef SPLIT_DROP_CNT_EN
  logic [CNT_W-1:0] drop_cnt_q;

  always_ff @(posedge clk_var) begin
    if (reset) begin
      drop_cnt_q <= '0;
    end else if (drop && (drop_cnt_q != {CNT_W{1'b1}})) begin
      drop_cnt_q <= drop_cnt_q + 1'b1;
    end
  end

  assign drop_count = drop_cnt_q;
`else
  assign drop_count = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_polyphase_split.sv
// Directed bench for polyphase_split: a vector table for the streaming cases plus
// hand-written sequences for overflow, full push+pop, mid-pair reset and enable freeze.
module tb_polyphase_split;

  logic        clk_var = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [7:0]  even_data;
  logic [7:0]  odd_data;
  logic        branch_en;
  logic [2:0]  fifo_level;
  logic        overflow;
  logic [15:0] drop_count;
  logic        phase_dbg;

  int total = 0;
  int bad = 0;

  logic [15:0] exp_q[$];

  typedef struct {
    logic       vld;
    logic [7:0] din;
    logic       rdy;
    logic       br;
    logic [7:0] ev;
    logic [7:0] od;
    logic [2:0] lvl;
  } vec_t;

  vec_t vecs[12];

  polyphase_split #(.DATA_W(8), .FIFO_DEPTH(4), .CNT_W(16)) dut (
    .clk_var    (clk_var),
    .reset      (reset),
    .enable     (enable),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .out_ready  (out_ready),
    .even_data  (even_data),
    .odd_data   (odd_data),
    .branch_en  (branch_en),
    .fifo_level (fifo_level),
    .overflow   (overflow),
    .drop_count (drop_count),
    .phase_dbg  (phase_dbg)
  );

  // clock / reset
  always #5 clk_var = ~clk_var;

  task automatic tick();
    @(posedge clk_var);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    enable = 1'b1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic send(input logic [7:0] d);
    in_valid = 1'b1;
    in_data = d;
    tick();
  endtask

  logic [15:0] t3_exp [4] = '{16'h2223, 16'h2425, 16'h2627, 16'h3031};
  logic [15:0] exp_drop;

  initial begin
`ifdef SPLIT_DROP_CNT_EN
    exp_drop = 16'd1;
`else
    exp_drop = 16'd0;
`endif
    // streaming pairs, then a pair split by idle gaps
    vecs[0]  = '{1'b1, 8'h01, 1'b1, 1'b0, 8'h00, 8'h00, 3'd0};
    vecs[1]  = '{1'b1, 8'h02, 1'b1, 1'b0, 8'h00, 8'h00, 3'd1};
    vecs[2]  = '{1'b1, 8'h03, 1'b1, 1'b1, 8'h01, 8'h02, 3'd0};
    vecs[3]  = '{1'b1, 8'h04, 1'b1, 1'b0, 8'h01, 8'h02, 3'd1};
    vecs[4]  = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h03, 8'h04, 3'd0};
    vecs[5]  = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h03, 8'h04, 3'd0};
    vecs[6]  = '{1'b1, 8'hA0, 1'b1, 1'b0, 8'h03, 8'h04, 3'd0};
    vecs[7]  = '{1'b0, 8'hEE, 1'b1, 1'b0, 8'h03, 8'h04, 3'd0};
    vecs[8]  = '{1'b0, 8'hEE, 1'b1, 1'b0, 8'h03, 8'h04, 3'd0};
    vecs[9]  = '{1'b1, 8'hA1, 1'b1, 1'b0, 8'h03, 8'h04, 3'd1};
    vecs[10] = '{1'b0, 8'h00, 1'b1, 1'b1, 8'hA0, 8'hA1, 3'd0};
    vecs[11] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'hA0, 8'hA1, 3'd0};

    do_reset();
    check("rst_even", {24'd0, even_data}, 32'h0);
    check("rst_odd", {24'd0, odd_data}, 32'h0);
    check("rst_br", {31'd0, branch_en}, 32'h0);
    check("rst_lvl", {29'd0, fifo_level}, 32'h0);
    check("rst_ovf", {31'd0, overflow}, 32'h0);
    check("rst_drop", {16'd0, drop_count}, 32'h0);
    check("rst_phase", {31'd0, phase_dbg}, 32'h0);

    for (int i = 0; i < 12; i++) begin
      in_valid = vecs[i].vld;
      in_data = vecs[i].din;
      out_ready = vecs[i].rdy;
      tick();
      check($sformatf("vec%0d_br", i), {31'd0, branch_en}, {31'd0, vecs[i].br});
      check($sformatf("vec%0d_even", i), {24'd0, even_data}, {24'd0, vecs[i].ev});
      check($sformatf("vec%0d_odd", i), {24'd0, odd_data}, {24'd0, vecs[i].od});
      check($sformatf("vec%0d_lvl", i), {29'd0, fifo_level}, {29'd0, vecs[i].lvl});
    end
    check("stream_ovf", {31'd0, overflow}, 32'h0);

    // overflow: 5 pairs into a depth-4 FIFO with no drain
    do_reset();
    exp_q.delete();
    for (int k = 0; k < 5; k++) begin
      send(8'h10 + 8'(2 * k));
      send(8'h11 + 8'(2 * k));
      if (k < 4) exp_q.push_back({8'h10 + 8'(2 * k), 8'h11 + 8'(2 * k)});
      if (k == 3) begin
        check("ovf_lvl_full", {29'd0, fifo_level}, 32'd4);
        check("ovf_pre", {31'd0, overflow}, 32'h0);
      end
    end
    in_valid = 1'b0;
    check("ovf_lvl", {29'd0, fifo_level}, 32'd4);
    check("ovf_flag", {31'd0, overflow}, 32'h1);
    check("ovf_drop", {16'd0, drop_count}, {16'd0, exp_drop});
    check("ovf_phase", {31'd0, phase_dbg}, 32'h0);
    out_ready = 1'b1;
    begin
      int pulses;
      pulses = 0;
      for (int c = 0; c < 8; c++) begin
        tick();
        if (branch_en) begin
          pulses++;
          if (exp_q.size() > 0) begin
            logic [15:0] e;
            e = exp_q.pop_front();
            check("drain_pair", {16'd0, even_data, odd_data}, {16'd0, e});
          end else begin
            check("drain_extra", {16'd0, even_data, odd_data}, 32'hFFFF_FFFF);
          end
        end
      end
      check("drain_pulses", pulses, 32'd4);
    end
    check("drain_left", exp_q.size(), 32'd0);
    check("drain_lvl", {29'd0, fifo_level}, 32'd0);
    check("drain_ovf_sticky", {31'd0, overflow}, 32'h1);

    // full FIFO with a same-cycle push and pop
    do_reset();
    for (int k = 0; k < 4; k++) begin
      send(8'h20 + 8'(2 * k));
      send(8'h21 + 8'(2 * k));
    end
    send(8'h30);
    check("full_lvl", {29'd0, fifo_level}, 32'd4);
    out_ready = 1'b1;
    send(8'h31);
    check("pp_br", {31'd0, branch_en}, 32'h1);
    check("pp_pair", {16'd0, even_data, odd_data}, 32'h2021);
    check("pp_lvl", {29'd0, fifo_level}, 32'd4);
    check("pp_ovf", {31'd0, overflow}, 32'h0);
    check("pp_drop", {16'd0, drop_count}, 32'h0);
    in_valid = 1'b0;
    out_ready = 1'b0;
    tick();
    check("pp_hold_br", {31'd0, branch_en}, 32'h0);
    check("pp_hold_lvl", {29'd0, fifo_level}, 32'd4);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("pp_drain%0d_br", i), {31'd0, branch_en}, 32'h1);
      check($sformatf("pp_drain%0d_pair", i), {16'd0, even_data, odd_data}, {16'd0, t3_exp[i]});
    end
    tick();
    check("pp_empty_br", {31'd0, branch_en}, 32'h0);

    // reset while holding an even sample
    do_reset();
    out_ready = 1'b1;
    send(8'h55);
    check("mid_phase", {31'd0, phase_dbg}, 32'h1);
    in_valid = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mid_rst_phase", {31'd0, phase_dbg}, 32'h0);
    send(8'h66);
    send(8'h77);
    in_valid = 1'b0;
    tick();
    check("mid_br", {31'd0, branch_en}, 32'h1);
    check("mid_pair", {16'd0, even_data, odd_data}, 32'h6677);

    // enable freeze with a non-empty FIFO
    do_reset();
    send(8'hC0);
    send(8'hC1);
    send(8'hC2);
    send(8'hC3);
    check("frz_lvl0", {29'd0, fifo_level}, 32'd2);
    enable = 1'b0;
    out_ready = 1'b1;
    in_valid = 1'b1;
    in_data = 8'hEE;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("frz%0d_br", i), {31'd0, branch_en}, 32'h0);
      check($sformatf("frz%0d_lvl", i), {29'd0, fifo_level}, 32'd2);
      check($sformatf("frz%0d_phase", i), {31'd0, phase_dbg}, 32'h0);
    end
    enable = 1'b1;
    in_valid = 1'b0;
    tick();
    check("res_br0", {31'd0, branch_en}, 32'h1);
    check("res_pair0", {16'd0, even_data, odd_data}, 32'hC0C1);
    check("res_lvl0", {29'd0, fifo_level}, 32'd1);
    tick();
    check("res_br1", {31'd0, branch_en}, 32'h1);
    check("res_pair1", {16'd0, even_data, odd_data}, 32'hC2C3);
    check("res_lvl1", {29'd0, fifo_level}, 32'd0);
    tick();
    check("res_idle", {31'd0, branch_en}, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
